// File: rtl/axi4_pkg.sv
// ----------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 definitions for the memory master and its helpers:
//   - bus width constants (ADDR_W, DATA_W, ID_W, STRB_W, LEN_W, SIZE_W)
//   - burst encodings (FIXED / INCR / WRAP)
//   - response encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   - master FSM state enum (IDLE, AR, R, WR, B)
// ----------------------------------------------------------------------------
package axi4_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        WR,
        B
    } state_t;

endpackage

// File: rtl/axi4_mem_master_if.sv
// ----------------------------------------------------------------------------
// axi4_mem_master_if
// AXI4 bus between the memory master and the SRAM responder.
// Channels: AR (arid/araddr/arlen/arsize/arburst/arvalid/arready),
//           R  (rid/rdata/rresp/rlast/rvalid/rready),
//           AW (awid/awaddr/awlen/awsize/awburst/awvalid/awready),
//           W  (wdata/wstrb/wlast/wvalid/wready),
//           B  (bid/bresp/bvalid/bready).
// Modports: master (initiator side), slave (responder side).
// ----------------------------------------------------------------------------
interface axi4_mem_master_if;
    import axi4_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [SIZE_W-1:0] arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [SIZE_W-1:0] awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi4_mst_watchdog.sv
// ----------------------------------------------------------------------------
// axi4_mst_watchdog
// Stall watchdog for the AXI4 memory master. Only instantiated when the
// AXI_MST_TIMEOUT_EN macro is defined.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   active          master is outside IDLE
//   handshake       any bus handshake this cycle
//   state, addr     reported when the watchdog fires
//   timeout_err     sticky flag, cleared only by reset
// ----------------------------------------------------------------------------
module axi4_mst_watchdog
    import axi4_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              active,
    input  logic              handshake,
    input  state_t            state,
    input  logic [ADDR_W-1:0] addr,
    output logic              timeout_err
);

    localparam logic [15:0] LIMIT = TIMEOUT_CYC[15:0];

    logic [15:0] wd_cnt;
    logic        fire;

    assign fire = (wd_cnt == LIMIT) && !timeout_err;

    // Counts idle-bus cycles of an active transaction; the count saturates at
    // the limit so a long stall cannot wrap around and re-arm the flag.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!active || handshake)
                wd_cnt <= '0;
            else if (wd_cnt != LIMIT)
                wd_cnt <= wd_cnt + 16'd1;
            if (fire)
                timeout_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge aclk) begin
        if (aresetn && fire)
            $display("axi4_mst_watchdog: timeout in state %s addr 0x%08h", state.name(), addr);
    end
`endif

endmodule

// File: rtl/axi4_mem_master.sv
// ----------------------------------------------------------------------------
// axi4_mem_master
// AXI4 initiator bridging the core's simple request/response interface to
// the AXI4 bus. One outstanding transaction: an INCR read burst (up to 256
// beats) or a single-beat write. Read beats pass straight through to the
// response port; write completion is reported as one response.
// Ports:
//   aclk, aresetn                      clock, synchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_we/addr/len/size/wdata/wstrb   request payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_data/rsp_last/rsp_err          response payload
//   bus                                AXI4 master modport
//   timeout_err                        sticky watchdog flag
// Optional feature: define AXI_MST_TIMEOUT_EN to build the stall watchdog;
// otherwise timeout_err is tied to 0.
// ----------------------------------------------------------------------------
module axi4_mem_master
    import axi4_pkg::*;
#(
    parameter logic [ID_W-1:0] AXI_ID      = 4'd0,
    parameter int              TIMEOUT_CYC = 1024
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [SIZE_W-1:0]  req_size,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic [STRB_W-1:0]  req_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_last,
    output logic               rsp_err,
    axi4_mem_master_if.master  bus,
    output logic               timeout_err
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [LEN_W-1:0]  lat_len;
    logic [SIZE_W-1:0] lat_size;
    logic [DATA_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;
    logic [LEN_W-1:0]  beat_cnt;
    logic              aw_done, w_done;

    logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign accept = req_valid & req_ready;
    assign ar_hs  = bus.arvalid & bus.arready;
    assign r_hs   = bus.rvalid & bus.rready;
    assign aw_hs  = bus.awvalid & bus.awready;
    assign w_hs   = bus.wvalid & bus.wready;
    assign b_hs   = bus.bvalid & bus.bready;

    // Payloads come straight from the request latch so they stay stable for
    // as long as the corresponding valid is held.
    assign bus.arid    = AXI_ID;
    assign bus.araddr  = lat_addr;
    assign bus.arlen   = lat_len;
    assign bus.arsize  = lat_size;
    assign bus.arburst = BURST_INCR;
    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = lat_addr;
    assign bus.awlen   = '0;
    assign bus.awsize  = lat_size;
    assign bus.awburst = BURST_INCR;
    assign bus.wdata   = lat_wdata;
    assign bus.wstrb   = lat_wstrb;
    assign bus.wlast   = 1'b1;

    // State register; reset abandons any bus transaction in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. WR leaves once each of AW and W has completed, either
    // in an earlier cycle or in this one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_we ? WR : AR;
            AR:      if (ar_hs) state_nxt = R;
            R:       if (r_hs && bus.rlast) state_nxt = IDLE;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = B;
            B:       if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read beat counter and per-channel write completion.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lat_addr  <= '0;
            lat_len   <= '0;
            lat_size  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            beat_cnt  <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (accept) begin
                lat_addr  <= req_addr;
                lat_len   <= req_we ? '0 : req_len;
                lat_size  <= req_size;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                beat_cnt  <= '0;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
            end
            if (r_hs)
                beat_cnt <= beat_cnt + 8'd1;
            if (aw_hs)
                aw_done <= 1'b1;
            if (w_hs)
                w_done <= 1'b1;
        end
    end

    // Output decode. req_ready is gated by aresetn so nothing reads as ready
    // while reset is held. The rlast check flags both early and late rlast.
    always_comb begin
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_last    = 1'b0;
        rsp_err     = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        case (state)
            IDLE: req_ready = aresetn;
            AR:   bus.arvalid = 1'b1;
            R: begin
                bus.rready = rsp_ready;
                rsp_valid  = bus.rvalid;
                rsp_data   = bus.rdata;
                rsp_last   = bus.rlast;
                rsp_err    = (bus.rresp != RESP_OKAY) || (bus.rid != AXI_ID) ||
                             (bus.rlast != (beat_cnt == lat_len));
            end
            WR: begin
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
            end
            B: begin
                bus.bready = rsp_ready;
                rsp_valid  = bus.bvalid;
                rsp_last   = 1'b1;
                rsp_err    = (bus.bresp != RESP_OKAY) || (bus.bid != AXI_ID);
            end
            default: ;
        endcase
    end

`ifdef AXI_MST_TIMEOUT_EN
    axi4_mst_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .active      (state != IDLE),
        .handshake   (ar_hs || r_hs || aw_hs || w_hs || b_hs),
        .state       (state),
        .addr        (lat_addr),
        .timeout_err (timeout_err)
    );
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_mem_master.sv
// ----------------------------------------------------------------------------
// tb_axi4_mem_master
// Directed test of axi4_mem_master against a small SRAM responder model.
// Expected responses and bus payloads are queued when a request is issued;
// a monitor on the falling edge pops and compares on every handshake.
// ----------------------------------------------------------------------------
module tb_axi4_mem_master;
    import axi4_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        err;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
    } w_exp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [2:0]  req_size = 3'd3;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    rsp_exp_t    rsp_q[$];
    ar_exp_t     ar_q[$];
    logic [31:0] aw_q[$];
    w_exp_t      w_q[$];

    // Responder knobs
    int hold_ar  = 0;
    int err_beat = -1;
    int len_adj  = 0;
    int w_delay  = 0;

    logic [63:0] mem [0:511];

    always #5 aclk = ~aclk;

    axi4_mem_master_if bus ();

    axi4_mem_master #(
        .AXI_ID      (4'd0),
        .TIMEOUT_CYC (1024)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .rsp_err     (rsp_err),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic noteTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired (rsp_q=%0d ar_q=%0d)", name, rsp_q.size(), ar_q.size());
    endtask

    // SRAM responder: one-cycle arready/awready pulses, wready after w_delay
    // cycles, back-to-back read beats while rready is high.
    int          r_next, r_len;
    logic        r_active;
    logic [8:0]  r_base;
    int          w_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_cap;
    logic [63:0] w_data_cap;
    logic [7:0]  w_strb_cap;

    always @(posedge aclk) begin
        if (!aresetn) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= 2'b00;
            bus.rid     <= '0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            bus.bid     <= '0;
            r_active    <= 1'b0;
            r_next      <= 0;
            r_len       <= 0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            w_wait      <= 0;
        end else begin
            bus.arready <= bus.arvalid && !bus.arready && (hold_ar == 0);
            if (bus.arvalid && bus.arready) begin
                r_active <= 1'b1;
                r_next   <= 0;
                r_len    <= int'(bus.arlen) + len_adj;
                r_base   <= bus.araddr[11:3];
            end
            if (r_active && (!bus.rvalid || bus.rready)) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= mem[r_base + 9'(r_next)];
                bus.rlast  <= (r_next == r_len);
                bus.rresp  <= (r_next == err_beat) ? 2'b10 : 2'b00;
                r_next     <= r_next + 1;
                if (r_next == r_len)
                    r_active <= 1'b0;
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
                bus.rlast  <= 1'b0;
            end

            bus.awready <= bus.awvalid && !bus.awready;
            if (bus.wvalid && !bus.wready)
                w_wait <= w_wait + 1;
            else
                w_wait <= 0;
            bus.wready <= bus.wvalid && !bus.wready && (w_wait >= w_delay);
            if (bus.awvalid && bus.awready) begin
                aw_got      <= 1'b1;
                aw_addr_cap <= bus.awaddr;
            end
            if (bus.wvalid && bus.wready) begin
                w_got      <= 1'b1;
                w_data_cap <= bus.wdata;
                w_strb_cap <= bus.wstrb;
            end
            if (aw_got && w_got && !bus.bvalid) begin
                for (int b = 0; b < 8; b++)
                    if (w_strb_cap[b])
                        mem[aw_addr_cap[11:3]][b*8 +: 8] <= w_data_cap[b*8 +: 8];
                bus.bvalid <= 1'b1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
            end
        end
    end

    // Scoreboard monitor: compares on every handshake, away from the clock edge.
    rsp_exp_t    mon_r;
    ar_exp_t     mon_ar;
    logic [31:0] mon_aw;
    w_exp_t      mon_w;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL rsp_unexpected: got data 0x%0h last %0b with nothing queued", rsp_data, rsp_last);
                end else begin
                    mon_r = rsp_q.pop_front();
                    checkOutput("rsp_data", rsp_data, mon_r.data);
                    checkOutput("rsp_last", rsp_last, mon_r.last);
                    checkOutput("rsp_err", rsp_err, mon_r.err);
                end
            end
            if (bus.rvalid)
                checkOutput("rready_mirror", bus.rready, rsp_ready);
            if (bus.arvalid && bus.arready) begin
                if (ar_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL ar_unexpected: got araddr 0x%0h", bus.araddr);
                end else begin
                    mon_ar = ar_q.pop_front();
                    checkOutput("araddr", bus.araddr, mon_ar.addr);
                    checkOutput("arlen", bus.arlen, mon_ar.len);
                    checkOutput("arburst_arsize_arid", {bus.arburst, bus.arsize, bus.arid}, {2'b01, 3'd3, 4'd0});
                end
            end
            if (bus.awvalid && bus.awready) begin
                if (aw_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL aw_unexpected: got awaddr 0x%0h", bus.awaddr);
                end else begin
                    mon_aw = aw_q.pop_front();
                    checkOutput("awaddr", bus.awaddr, mon_aw);
                    checkOutput("awlen_awburst", {bus.awlen, bus.awburst}, {8'd0, 2'b01});
                end
            end
            if (bus.wvalid && bus.wready) begin
                if (w_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL w_unexpected: got wdata 0x%0h", bus.wdata);
                end else begin
                    mon_w = w_q.pop_front();
                    checkOutput("wdata", bus.wdata, mon_w.data);
                    checkOutput("wstrb_wlast", {bus.wstrb, bus.wlast}, {mon_w.strb, 1'b1});
                end
            end
        end
    end

    // Issue one request, wait (bounded) for acceptance, then check that the
    // bus side starts in the very next cycle.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [63:0] wdata, input logic [7:0] wstrb);
        int   budget;
        logic seen;
        budget    = 200;
        seen      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        req_size  = 3'd3;
        req_wdata = wdata;
        req_wstrb = wstrb;
        while (!seen && budget > 0) begin
            @(negedge aclk);
            seen = req_ready;
            @(posedge aclk);
            #1;
            budget--;
        end
        req_valid = 1'b0;
        if (!seen)
            noteTimeout("req_accept");
        else if (we)
            checkOutput("aw_w_rise_n1", {bus.awvalid, bus.wvalid}, 2'b11);
        else
            checkOutput("arvalid_n1", bus.arvalid, 1'b1);
    endtask

    task automatic waitDrain(input int budget);
        while ((rsp_q.size() + ar_q.size() + aw_q.size() + w_q.size()) != 0 && budget > 0) begin
            @(posedge aclk);
            #1;
            budget--;
        end
        if (budget == 0)
            noteTimeout("drain");
    endtask

    task automatic pushRsp(input logic [63:0] data, input logic last, input logic err);
        rsp_q.push_back('{data: data, last: last, err: err});
    endtask

    task automatic pushAr(input logic [31:0] addr, input logic [7:0] len);
        ar_q.push_back('{addr: addr, len: len});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int bp_pat[4] = '{1, 0, 0, 1};
        int budget;
        int k;

        for (int i = 0; i < 512; i++)
            mem[i] = 64'h0;
        mem[0] = 64'h1122334455667788;
        mem[1] = 64'hAAAAAAAA55555555;
        for (int i = 0; i < 4; i++)
            mem[32 + i] = 64'(i);
        for (int i = 0; i < 256; i++)
            mem[256 + i] = 64'hA500000000000000 | 64'(i);

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset_req_ready", req_ready, 1'b0);
        checkOutput("reset_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, rsp_valid}, 6'b0);
        checkOutput("reset_timeout_err", timeout_err, 1'b0);
        aresetn = 1'b1;
        #1;
        checkOutput("req_ready_after_reset", req_ready, 1'b1);

        // Single read
        $display("[TB] single read");
        pushAr(32'h80000000, 8'd0);
        pushRsp(64'h1122334455667788, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h80000000, 8'd0, '0, '0);
        waitDrain(100);

        // Burst read of 4
        $display("[TB] burst read");
        pushAr(32'h80000100, 8'd3);
        for (int i = 0; i < 4; i++)
            pushRsp(64'(i), (i == 3), 1'b0);
        applyStimulus(1'b0, 32'h80000100, 8'd3, '0, '0);
        waitDrain(100);

        // Burst read with rsp_ready toggling 1,0,0,1
        $display("[TB] backpressure");
        pushAr(32'h80000100, 8'd3);
        for (int i = 0; i < 4; i++)
            pushRsp(64'(i), (i == 3), 1'b0);
        applyStimulus(1'b0, 32'h80000100, 8'd3, '0, '0);
        k = 0;
        budget = 100;
        while (rsp_q.size() != 0 && budget > 0) begin
            rsp_ready = (bp_pat[k % 4] != 0);
            @(posedge aclk);
            #1;
            k++;
            budget--;
        end
        rsp_ready = 1'b1;
        waitDrain(100);

        // Write with same-cycle AW/W handshake, then read back
        $display("[TB] write same-cycle");
        w_delay = 0;
        aw_q.push_back(32'h80000008);
        w_q.push_back('{data: 64'h00000000DEADBEEF, strb: 8'h0F});
        pushRsp(64'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h80000008, 8'd5, 64'h00000000DEADBEEF, 8'h0F);
        waitDrain(100);
        pushAr(32'h80000008, 8'd0);
        pushRsp(64'hAAAAAAAADEADBEEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h80000008, 8'd0, '0, '0);
        waitDrain(100);

        // Write with W handshake lagging AW, then read back
        $display("[TB] write split handshake");
        w_delay = 2;
        aw_q.push_back(32'h80000010);
        w_q.push_back('{data: 64'h123456789ABCDEF0, strb: 8'hF0});
        pushRsp(64'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h80000010, 8'd0, 64'h123456789ABCDEF0, 8'hF0);
        waitDrain(100);
        w_delay = 0;
        pushAr(32'h80000010, 8'd0);
        pushRsp(64'h1234567800000000, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h80000010, 8'd0, '0, '0);
        waitDrain(100);

        // SLVERR on beat index 2 only
        $display("[TB] error beat");
        err_beat = 2;
        pushAr(32'h80000100, 8'd3);
        for (int i = 0; i < 4; i++)
            pushRsp(64'(i), (i == 3), (i == 2));
        applyStimulus(1'b0, 32'h80000100, 8'd3, '0, '0);
        waitDrain(100);
        err_beat = -1;

        // rlast two beats early
        $display("[TB] early rlast");
        len_adj = -2;
        pushAr(32'h80000100, 8'd3);
        pushRsp(64'd0, 1'b0, 1'b0);
        pushRsp(64'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h80000100, 8'd3, '0, '0);
        waitDrain(100);

        // rlast one beat late
        $display("[TB] late rlast");
        len_adj = 1;
        pushAr(32'h80000100, 8'd1);
        pushRsp(64'd0, 1'b0, 1'b0);
        pushRsp(64'd1, 1'b0, 1'b1);
        pushRsp(64'd2, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h80000100, 8'd1, '0, '0);
        waitDrain(100);
        len_adj = 0;

        // Maximum burst length
        $display("[TB] 256-beat burst");
        pushAr(32'h80000800, 8'd255);
        for (int i = 0; i < 256; i++)
            pushRsp(64'hA500000000000000 | 64'(i), (i == 255), 1'b0);
        applyStimulus(1'b0, 32'h80000800, 8'd255, '0, '0);
        waitDrain(400);

        // Reset while beat index 2 of 4 is on the bus
        $display("[TB] reset mid-burst");
        pushAr(32'h80000100, 8'd3);
        pushRsp(64'd0, 1'b0, 1'b0);
        pushRsp(64'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h80000100, 8'd3, '0, '0);
        waitDrain(100);
        rsp_ready = 1'b0;
        aresetn   = 1'b0;
        @(posedge aclk);
        #1;
        checkOutput("midreset_arvalid_rready", {bus.arvalid, bus.rready}, 2'b00);
        checkOutput("midreset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("midreset_req_ready", req_ready, 1'b0);
        @(posedge aclk);
        #1;
        aresetn   = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checkOutput("req_ready_after_midreset", req_ready, 1'b1);
        pushAr(32'h80000000, 8'd0);
        pushRsp(64'h1122334455667788, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h80000000, 8'd0, '0, '0);
        waitDrain(100);

`ifdef AXI_MST_TIMEOUT_EN
        // AR never accepted: watchdog must fire
        $display("[TB] watchdog");
        hold_ar = 1;
        applyStimulus(1'b0, 32'h80000040, 8'd0, '0, '0);
        budget = 1300;
        while (!timeout_err && budget > 0) begin
            @(posedge aclk);
            #1;
            budget--;
        end
        checkOutput("timeout_err_set", timeout_err, 1'b1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        checkOutput("timeout_err_cleared", timeout_err, 1'b0);
        hold_ar = 0;
        aresetn = 1'b1;
`else
        checkOutput("timeout_err_tied", timeout_err, 1'b0);
`endif

        repeat (2) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
